// File: rtl/sdram_sum_sequencer_pkg.sv
// Shared types and constants for the SDRAM sum sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lab4_sdram_pkg;

    // Sequencer states; the FSM carries them as plain 3-bit codes.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_WR_LO = 3'd3,
        ST_WR_HI = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    localparam int SDRAM_DW   = 16;
    localparam int SUM_W      = 32;
    localparam int WORD_BYTES = 2;

    // Width needed to hold 0..max_pending inclusive.
    function automatic int pend_w(input int max_pending);
        return $clog2(max_pending + 1);
    endfunction

endpackage

// File: rtl/sdram_sum_sequencer_if.sv
// Avalon-MM master bundle between the sequencer and the SDRAM controller slave.
// Latency: n/a (wires only).
// Backpressure: slave stalls the master with waitrequest; reads return in order on readdatavalid.
// Ports: address/read/write/writedata/byteenable flow master->slave,
//        readdata/readdatavalid/waitrequest flow slave->master.
interface sdram_sum_sequencer_if
    import lab4_sdram_pkg::*;
#(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0]   address;
    logic                read;
    logic                write;
    logic [SDRAM_DW-1:0] writedata;
    logic [1:0]          byteenable;
    logic [SDRAM_DW-1:0] readdata;
    logic                readdatavalid;
    logic                waitrequest;

    modport master (
        output address, read, write, writedata, byteenable,
        input  readdata, readdatavalid, waitrequest
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output readdata, readdatavalid, waitrequest
    );
endinterface

// File: rtl/sdram_sum_sequencer_pending_ctr.sv
// Up/down counter of reads in flight, with a full flag at MAX_PENDING.
// Latency: count updates on the clock edge after inc/dec.
// Backpressure: full_o tells the issuer to stop launching reads.
// Ports: clk/reset, clr_i (synchronous clear), inc_i (read accepted),
//        dec_i (read data returned), full_o (count == MAX_PENDING).
module avm_pending_ctr
    import lab4_sdram_pkg::*;
#(
    parameter int MAX_PENDING = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic inc_i,
    input  logic dec_i,
    output logic full_o
);
    localparam int PEND_W = pend_w(MAX_PENDING);

    logic [PEND_W-1:0] count_q;
    logic [PEND_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && !dec_i) begin
            count_d = count_q + PEND_W'(1);
        end else if (dec_i && !inc_i && (count_q != '0)) begin
            count_d = count_q - PEND_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign full_o = (count_q == PEND_W'(MAX_PENDING));

endmodule

// File: rtl/sdram_sum_sequencer.sv
// Per HPS request: pipelined 16-bit reads over cfg_len words, 32-bit sum, sum written back as two halfwords.
// Latency: done rises about cfg_len+4 cycles after launch with zero wait states and 1-cycle read latency.
// Backpressure: honours avm waitrequest (request held stable); at most MAX_PENDING reads outstanding.
// Ports: clk, reset (async, active high); start/cfg_len/done/tohexled HPS conduit;
//        avm = Avalon-MM master towards the SDRAM controller.
module sdram_sum_sequencer
    import lab4_sdram_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter logic [ADDR_W-1:0] RESULT_ADDR = ADDR_W'(32'h0010_0000),
    parameter int                MAX_PENDING = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [15:0]           cfg_len,
    output logic                  done,
    output logic [SUM_W-1:0]      tohexled,
    sdram_sum_sequencer_if.master avm
);
    localparam logic [2:0] S_IDLE  = ST_IDLE;
    localparam logic [2:0] S_READ  = ST_READ;
    localparam logic [2:0] S_DRAIN = ST_DRAIN;
    localparam logic [2:0] S_WR_LO = ST_WR_LO;
    localparam logic [2:0] S_WR_HI = ST_WR_HI;
    localparam logic [2:0] S_DONE  = ST_DONE;

    logic [2:0]       state_q, state_d;
    logic             start_q;
    logic [15:0]      len_q, len_d;
    logic [15:0]      issued_q, issued_d;
    logic [15:0]      received_q, received_d;
    logic [SUM_W-1:0] sum_q, sum_d;
    logic             done_q, done_d;
    logic [SUM_W-1:0] hex_q, hex_d;

    logic              rd_req, wr_req;
    logic [ADDR_W-1:0] addr_c;
    logic [15:0]       wdata_c;
    logic              rd_acc, wr_acc, rdv_ok;
    logic              pend_clr, pend_full;
    logic [DATA_W-1:0] rd_word;

    assign rd_word = avm.readdata;

    // Request generation depends only on registered state, so read/address
    // cannot change while the slave stalls: issued only moves on accept and
    // pending can only fall during a stall.
    always_comb begin
        rd_req  = 1'b0;
        wr_req  = 1'b0;
        addr_c  = '0;
        wdata_c = '0;
        case (state_q)
            S_READ: begin
                addr_c = BASE_ADDR + ADDR_W'(32'(issued_q) * WORD_BYTES);
                rd_req = (issued_q < len_q) && !pend_full;
            end
            S_WR_LO: begin
                wr_req  = 1'b1;
                addr_c  = RESULT_ADDR;
                wdata_c = sum_q[15:0];
            end
            S_WR_HI: begin
                wr_req  = 1'b1;
                addr_c  = RESULT_ADDR + ADDR_W'(WORD_BYTES);
                wdata_c = sum_q[31:16];
            end
            default: begin
                rd_req = 1'b0;
            end
        endcase
    end

    assign rd_acc = rd_req && !avm.waitrequest;
    assign wr_acc = wr_req && !avm.waitrequest;
    // Stray strobes outside a pass (e.g. in flight across a reset) are dropped.
    assign rdv_ok = avm.readdatavalid && ((state_q == S_READ) || (state_q == S_DRAIN));

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        issued_d   = issued_q;
        received_d = received_q;
        sum_d      = sum_q;
        done_d     = done_q;
        hex_d      = hex_q;
        pend_clr   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && !start_q) begin
                    len_d      = cfg_len;
                    issued_d   = '0;
                    received_d = '0;
                    sum_d      = '0;
                    pend_clr   = 1'b1;
                    state_d    = (cfg_len != 16'd0) ? S_READ : S_WR_LO;
                end
            end
            S_READ: begin
                if (rd_acc) begin
                    issued_d = issued_q + 16'd1;
                end
                // Exits one cycle after the final accept.
                if (issued_q == len_q) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (received_q == len_q) begin
                    state_d = S_WR_LO;
                end
            end
            S_WR_LO: begin
                if (wr_acc) begin
                    state_d = S_WR_HI;
                end
            end
            S_WR_HI: begin
                if (wr_acc) begin
                    hex_d   = sum_q;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // Four-phase: start must drop before another pass can launch.
                if (!start) begin
                    done_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (rdv_ok) begin
            sum_d      = sum_q + SUM_W'(rd_word);
            received_d = received_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            start_q    <= 1'b0;
            len_q      <= '0;
            issued_q   <= '0;
            received_q <= '0;
            sum_q      <= '0;
            done_q     <= 1'b0;
            hex_q      <= '0;
        end else begin
            state_q    <= state_d;
            start_q    <= start;
            len_q      <= len_d;
            issued_q   <= issued_d;
            received_q <= received_d;
            sum_q      <= sum_d;
            done_q     <= done_d;
            hex_q      <= hex_d;
        end
    end

    avm_pending_ctr #(
        .MAX_PENDING (MAX_PENDING)
    ) u_pending (
        .clk    (clk),
        .reset  (reset),
        .clr_i  (pend_clr),
        .inc_i  (rd_acc),
        .dec_i  (rdv_ok),
        .full_o (pend_full)
    );

    assign avm.address    = addr_c;
    assign avm.read       = rd_req;
    assign avm.write      = wr_req;
    assign avm.writedata  = wdata_c;
    assign avm.byteenable = 2'b11;
    assign done           = done_q;
    assign tohexled       = hex_q;

endmodule
